// File: rtl/spongent_pkg.sv
// Shared SPONGENT definitions: S-box, round-controller FSM encoding and default sizes.
package spongent_pkg;

  localparam int STATE_W_DEF = 264;
  localparam int ROUNDS_DEF  = 385;
  localparam int LCNT_W_DEF  = 9;
  localparam logic [8:0] LCNT_INIT_DEF = 9'h005;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADD_S  = 3'd1,
    P_RST  = 3'd2,
    P_WAIT = 3'd3,
    DONE   = 3'd4
  } round_state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'hD;
      4'h2: y = 4'hB;
      4'h3: y = 4'h0;
      4'h4: y = 4'h2;
      4'h5: y = 4'h1;
      4'h6: y = 4'h4;
      4'h7: y = 4'hF;
      4'h8: y = 4'h7;
      4'h9: y = 4'hA;
      4'hA: y = 4'h8;
      4'hB: y = 4'h5;
      4'hC: y = 4'h9;
      4'hD: y = 4'hC;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/spongent_lcounter.sv
// Round-constant LFSR: load seeds round 0, step advances one round; held otherwise.
module spongent_lcounter
  import spongent_pkg::*;
#(
  parameter int                LCNT_W    = LCNT_W_DEF,
  parameter logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LCNT_INIT_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [LCNT_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= LCNT_INIT;
    end else if (step) begin
      value <= {value[LCNT_W-2:0], value[LCNT_W-1] ^ value[4]};
    end
  end

endmodule

// File: rtl/spongent_round_ctrl.sv
// SPONGENT permutation round sequencer around an external pLayer; latency 1+ROUNDS*(2+W)+1, start ignored while busy.
// Optional SPONGENT_ABORT_EN adds an abort input that drops a run back to IDLE without done.
module spongent_round_ctrl
  import spongent_pkg::*;
#(
  parameter int                STATE_W   = STATE_W_DEF,
  parameter int                ROUNDS    = ROUNDS_DEF,
  parameter int                LCNT_W    = LCNT_W_DEF,
  parameter logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LCNT_INIT_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_out,
  output logic [STATE_W-1:0] player_state,
  output logic               player_rst,
  input  logic [STATE_W-1:0] player_out,
  input  logic               player_rdy
`ifdef SPONGENT_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam int RCNT_W = $clog2(ROUNDS + 1);

  round_state_t       state_q, state_d;
  logic [STATE_W-1:0] work_q;
  logic [STATE_W-1:0] mix;
  logic [STATE_W-1:0] sb;
  logic [RCNT_W-1:0]  rcnt_q;
  logic [RCNT_W-1:0]  rcnt_inc;
  logic [LCNT_W-1:0]  lc;
  logic               lc_load;
  logic               lc_step;

  spongent_lcounter #(
    .LCNT_W    (LCNT_W),
    .LCNT_INIT (LCNT_INIT)
  ) u_lcounter (
    .clk   (clk),
    .rst   (rst),
    .load  (lc_load),
    .step  (lc_step),
    .value (lc)
  );

  assign busy       = (state_q == ADD_S) || (state_q == P_RST) || (state_q == P_WAIT);
  assign player_rst = rst || (state_q == P_RST);
  assign rcnt_inc   = rcnt_q + RCNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // lc_step doubles as the "round accepted" strobe, so abort suppresses capture too.
  always_comb begin
    state_d = state_q;
    lc_load = 1'b0;
    lc_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done) begin
          state_d = ADD_S;
          lc_load = 1'b1;
        end
      end
      ADD_S:  state_d = P_RST;
      P_RST:  state_d = P_WAIT;
      P_WAIT: begin
        if (player_rdy) begin
          lc_step = 1'b1;
          state_d = (rcnt_inc < RCNT_W'(ROUNDS)) ? ADD_S : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef SPONGENT_ABORT_EN
    if (abort && busy) begin
      state_d = IDLE;
      lc_step = 1'b0;
    end
`endif
  end

  // Round constant enters the low bits as-is and the high bits bit-reversed.
  always_comb begin
    mix = work_q;
    mix[LCNT_W-1:0] = work_q[LCNT_W-1:0] ^ lc;
    for (int i = 0; i < LCNT_W; i++) begin
      mix[STATE_W-1-i] = mix[STATE_W-1-i] ^ lc[i];
    end
  end

  always_comb begin
    sb = '0;
    for (int k = 0; k < STATE_W / 4; k++) begin
      sb[4*k +: 4] = sbox(mix[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q       <= '0;
      player_state <= '0;
      state_out    <= '0;
      done         <= 1'b0;
      rcnt_q       <= '0;
    end else begin
      done <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (lc_load) begin
            work_q <= state_in;
            rcnt_q <= '0;
          end
        end
        ADD_S: player_state <= sb;
        P_WAIT: begin
          if (lc_step) begin
            work_q <= player_out;
            rcnt_q <= rcnt_inc;
          end
        end
        DONE:    state_out <= work_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spongent_round_ctrl.sv
// Randomized scoreboard bench for spongent_round_ctrl with a delayed pLayer stub.
module tb_spongent_round_ctrl;

  localparam int SW = 264;
  localparam int RN = 3;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] state_in;
  logic          busy;
  logic          done;
  logic [SW-1:0] state_out;
  logic [SW-1:0] player_state;
  logic          player_rst;
  logic [SW-1:0] player_out;
  logic          player_rdy = 1'b0;
`ifdef SPONGENT_ABORT_EN
  logic          abort;
`endif

  always #5 clk = ~clk;

  spongent_round_ctrl #(
    .STATE_W (SW),
    .ROUNDS  (RN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .state_in     (state_in),
    .busy         (busy),
    .done         (done),
    .state_out    (state_out),
    .player_state (player_state),
    .player_rst   (player_rst),
    .player_out   (player_out),
    .player_rdy   (player_rdy)
`ifdef SPONGENT_ABORT_EN
    ,
    .abort        (abort)
`endif
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int sb_tab[16] = '{14, 13, 11, 0, 2, 1, 4, 15, 7, 10, 8, 5, 9, 12, 3, 6};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: SPONGENT pLayer, bit j -> j*n/4 mod (n-1), top bit fixed.
  function automatic logic [SW-1:0] perm(input logic [SW-1:0] x);
    logic [SW-1:0] y;
    y = '0;
    y[SW-1] = x[SW-1];
    for (int j = 0; j < SW - 1; j++) y[(j * (SW / 4)) % (SW - 1)] = x[j];
    return y;
  endfunction

  function automatic logic [SW-1:0] model(input logic [SW-1:0] s_in);
    logic [SW-1:0] s;
    int lc;
    s  = s_in;
    lc = 5;
    for (int r = 0; r < RN; r++) begin
      for (int i = 0; i < LW; i++) begin
        s[i]      = s[i] ^ lc[i];
        s[SW-1-i] = s[SW-1-i] ^ lc[i];
      end
      for (int k = 0; k < SW / 4; k++) s[4*k +: 4] = 4'(sb_tab[s[4*k +: 4]]);
      s  = perm(s);
      lc = ((lc << 1) & 'h1FF) | (((lc >> 8) ^ (lc >> 4)) & 1);
    end
    return s;
  endfunction

  function automatic logic [SW-1:0] rnd_state();
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) s = {s[SW-33:0], 32'($urandom())};
    return s;
  endfunction

  // pLayer stub: rdy pdelay cycles after player_rst; optional spurious rdy in ADD_S/P_RST.
  int pdelay = 33;
  int pcnt = -1;
  int nrst = 0;
  bit spur_en = 1'b0;
  bit pre_rdy;

  assign player_out = perm(player_state);

  always @(negedge clk) begin
    pre_rdy = busy && (player_rst || pcnt <= 0);
    if (player_rst) begin
      pcnt = pdelay;
      if (busy) nrst++;
    end else if (pcnt >= 0) begin
      pcnt--;
    end
    player_rdy = (pcnt == 0) || (spur_en && pre_rdy);
  end

  typedef struct {
    logic [SW-1:0] res;
    int            t0;
    int            lat;
    int            bsy;
  } exp_t;

  exp_t sbq[$];
  int   busy_cnt = 0;
  int   done_seen = 0;
  int   n_expect = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
        end else begin
          e = sbq.pop_front();
          chk("state_out", state_out, e.res);
          chk_int("latency", cyc - e.t0, e.lat);
          chk_int("busy_cycles", busy_cnt, e.bsy);
        end
        busy_cnt = 0;
        done_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [SW-1:0] s, input int d, input bit expect_done);
    exp_t e;
    pdelay   = d;
    state_in = s;
    nrst     = 0;
    start    = 1'b1;
    if (expect_done) begin
      e.res = model(s);
      e.t0  = cyc;
      e.lat = 2 + RN * (2 + d);
      e.bsy = RN * (2 + d);
      sbq.push_back(e);
      n_expect++;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      checks++;
      $display("FAIL drain_timeout: pending=%0d busy=%0b, required 0 and 0", sbq.size(), busy);
      sbq.delete();
    end
    repeat (3) tick();
  endtask

  task automatic flush_run();
    n_expect -= sbq.size();
    sbq.delete();
  endtask

  initial begin
    logic [SW-1:0] exp0;
    logic [SW-1:0] prev;
    int n;
    int d0;

    rst      = 1'b1;
    start    = 1'b0;
    state_in = '0;
`ifdef SPONGENT_ABORT_EN
    abort    = 1'b0;
`endif
    tick();
    chk("reset_player_rst", player_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_state_out", state_out, 0);
    chk("reset_player_state", player_state, 0);
    rst = 1'b0;
    tick();

    // All-zero input: first round pLayer input is 8EEE..E1, held through P_WAIT.
    exp0 = {(SW/4){4'hE}};
    exp0[SW-1 -: 4] = 4'h8;
    exp0[3:0] = 4'h1;
    start_run('0, 33, 1'b1);
    n = 0;
    while (!player_rst && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      $display("FAIL player_rst_timeout: got no pulse, required one within 20 cycles");
    end
    tick();
    chk("round0_player_state", player_state, exp0);
    chk("busy_in_p_wait", busy, 1);
    repeat (20) tick();
    chk("round0_player_state_held", player_state, exp0);
    wait_drain(500);

    for (int i = 0; i < 6; i++) begin
      start_run(rnd_state(), $urandom_range(1, 6), 1'b1);
      wait_drain(500);
    end

    // Extra starts at cycles 5 and 20 of a run must be ignored.
    d0 = done_seen;
    start_run(rnd_state(), 10, 1'b1);
    repeat (4) tick();
    state_in = rnd_state();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    state_in = rnd_state();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain(500);
    chk_int("one_done_for_restarts", done_seen - d0, 1);

    // Start coinciding with done must be ignored.
    start_run(rnd_state(), 2, 1'b1);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL done_timeout: got no done, required one within 200 cycles");
    end
    state_in = rnd_state();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("start_with_done_ignored", busy, 0);
    wait_drain(500);

    // Reset 40 cycles into a run discards it.
    start_run(rnd_state(), 20, 1'b1);
    repeat (39) tick();
    rst = 1'b1;
    flush_run();
    tick();
    rst = 1'b0;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_state_out", state_out, 0);
    repeat (100) tick();
    start_run(rnd_state(), 4, 1'b1);
    wait_drain(500);

    // Spurious player_rdy outside P_WAIT.
    spur_en = 1'b1;
    start_run(rnd_state(), 5, 1'b1);
    wait_drain(500);
    spur_en = 1'b0;

`ifdef SPONGENT_ABORT_EN
    // Abort together with player_rdy in round 2.
    prev = state_out;
    d0 = done_seen;
    start_run(rnd_state(), 7, 1'b1);
    n = 0;
    while (!(nrst == 2 && pcnt == 1) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL abort_point_timeout: got no round-2 rdy, required one within 300 cycles");
    end
    abort = 1'b1;
    flush_run();
    tick();
    abort = 1'b0;
    busy_cnt = 0;
    chk("abort_busy", busy, 0);
    repeat (80) tick();
    chk_int("abort_no_done", done_seen - d0, 0);
    chk("abort_state_out_kept", state_out, prev);
    start_run(rnd_state(), 3, 1'b1);
    wait_drain(500);
`else
    prev = state_out;
`endif

    chk_int("total_dones", done_seen, n_expect);
    chk_int("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spongent_round_ctrl.md
SPONGENT_ROUND_CTRL -- requirements
Module: spongent_round_ctrl

Interface
REQ-001 SHALL have parameter STATE_W, default 264, meaning permutation state width in bits (multiple of 8).
REQ-002 SHALL have parameter ROUNDS, default 385, meaning permutation rounds per start.
REQ-003 SHALL have parameter LCNT_W, default 9, meaning round-counter LFSR width.
REQ-004 SHALL have parameter LCNT_INIT, default 9'h005, meaning LFSR value for round 0.
REQ-005 SHALL have ports:
  - clk  in  1  single clock, all logic on posedge.
  - rst  in  1  synchronous, active-high reset.
  - start  in  1  one-cycle request, sampled only in IDLE.
  - state_in  in  STATE_W  initial state, captured with start.
  - busy  out  1  high from cycle after accepted start until done.
  - done  out  1  one-cycle pulse when the final state is valid.
  - state_out  out  STATE_W  final state, held until next accepted start.
  - player_state  out  STATE_W  registered input to the pLayer instance.
  - player_rst  out  1  one-cycle restart pulse to the pLayer instance.
  - player_out  in  STATE_W  pLayer result.
  - player_rdy  in  1  pLayer result valid.

Function
REQ-006 SHALL implement FSM states IDLE, ADD_S, P_RST, P_WAIT, DONE.
REQ-007 SHALL in IDLE, on start, register state_in, load LFSR with LCNT_INIT, clear round count, and go to ADD_S.
REQ-008 SHALL in ADD_S, in one cycle:
  - XOR the LFSR into state[LCNT_W-1:0].
  - XOR the bit-reversed LFSR into state[STATE_W-1 -: LCNT_W].
  - Apply the 4-bit Spongent S-box to every nibble.
  - Register the result into player_state.
  - Go to P_RST.
REQ-009 SHALL in P_RST drive player_rst=1 for exactly one cycle, then go to P_WAIT.
REQ-010 SHALL in P_WAIT hold player_state constant until player_rdy=1; on that cycle capture player_out as working state, advance the LFSR, and increment the round count.
REQ-011 SHALL from P_WAIT go to ADD_S if round count < ROUNDS, else to DONE.
REQ-012 SHALL ignore player_rdy in every state except P_WAIT.
REQ-013 SHALL advance the LFSR as next = {lc[LCNT_W-2:0], lc[LCNT_W-1]^lc[4]}.
REQ-014 SHALL in DONE copy the working state to state_out, pulse done for one cycle, and return to IDLE.
REQ-015 SHALL assert busy exactly in ADD_S, P_RST and P_WAIT.
REQ-016 SHALL ignore start while busy; a start in the same cycle as done SHALL also be ignored.
REQ-017 SHALL have per-start latency (start to done) of 1 + ROUNDS*(2+W) + 1 cycles, W = cycles spent in P_WAIT.
REQ-018 SHALL use a round counter exactly wide enough for ROUNDS, with no wrap within a run.

Reset
REQ-019 SHALL, when rst=1 at a clock edge, go to IDLE and zero busy, done, state_out, player_state, LFSR and round count.
REQ-020 SHALL drive player_rst=1 during the reset cycle.
REQ-021 SHALL, on reset mid-run, discard the run without asserting done.

Configuration
REQ-022 SHALL, with SPONGENT_ABORT_EN defined, add input abort (1 bit):
  - abort=1 while busy returns the FSM to IDLE next cycle.
  - done is not pulsed and state_out is unchanged.
  - abort takes priority over player_rdy in the same cycle.
REQ-023 SHALL, without SPONGENT_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-024 SHALL take from shared package spongent_pkg:
  - S-box table E,D,B,0,2,1,4,F,7,A,8,5,9,C,3,6.
  - FSM state encoding.
  - Default STATE_W/ROUNDS/LCNT constants.
REQ-025 SHALL put the LFSR in sub-module spongent_lcounter (load, step, value).

Verification
REQ-026 SHALL cover: ROUNDS=1, state_in=0, start -> player_state = 0x8EEE...EE1 (top nibble 8, lowest nibble 1, all others E) in P_WAIT.
REQ-027 SHALL cover: stub pLayer with player_rdy 33 cycles after player_rst, ROUNDS=3 -> done exactly 1+3*35+1=107 cycles after start; busy high 105 cycles.
REQ-028 SHALL cover: start pulsed at cycles 5 and 20 of a run -> one done only; state_out matches the first run's model result.
REQ-029 SHALL cover: rst at cycle 40 of a run -> next cycle busy=0, done=0, state_out=0; new start then completes normally.
REQ-030 SHALL cover: spurious player_rdy during ADD_S/P_RST -> ignored, result unchanged versus golden model.
REQ-031 SHALL cover, with SPONGENT_ABORT_EN: abort and player_rdy together in round 2 -> IDLE, no done, state_out keeps previous value.
